// File: rtl/alu_pkg.sv
// Shared command encodings, collector states and operand-requirement helpers
// for the pipelined ALU core.
package alu_pkg;

  localparam int CMD_W = 4;

  typedef enum logic [CMD_W-1:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC_A   = 4'd4,
    A_DEC_A   = 4'd5,
    A_INC_B   = 4'd6,
    A_DEC_B   = 4'd7,
    A_CMP     = 4'd8,
    A_MUL_INC = 4'd9,
    A_MUL_SHL = 4'd10
  } arith_cmd_e;

  typedef enum logic [CMD_W-1:0] {
    L_AND     = 4'd0,
    L_NAND    = 4'd1,
    L_OR      = 4'd2,
    L_NOR     = 4'd3,
    L_XOR     = 4'd4,
    L_XNOR    = 4'd5,
    L_NOT_A   = 4'd6,
    L_NOT_B   = 4'd7,
    L_SHR1_A  = 4'd8,
    L_SHL1_A  = 4'd9,
    L_SHR1_B  = 4'd10,
    L_SHL1_B  = 4'd11,
    L_ROL_A_B = 4'd12,
    L_ROR_A_B = 4'd13
  } logic_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    MUL2 = 2'd2
  } coll_state_e;

  localparam logic [1:0] NEED_A  = 2'b01;
  localparam logic [1:0] NEED_B  = 2'b10;
  localparam logic [1:0] NEED_AB = 2'b11;

  // Operand requirement mask: bit0 = OPA needed, bit1 = OPB needed.
  // Unknown codes ask for both so they resolve as an error once complete.
  function automatic logic [1:0] needs_operands(input logic mode,
                                                input logic [CMD_W-1:0] cmd);
    logic [1:0] need;
    need = NEED_AB;
    if (mode) begin
      if (cmd == A_INC_A || cmd == A_DEC_A) need = NEED_A;
      else if (cmd == A_INC_B || cmd == A_DEC_B) need = NEED_B;
    end else begin
      if (cmd == L_NOT_A || cmd == L_SHR1_A || cmd == L_SHL1_A) need = NEED_A;
      else if (cmd == L_NOT_B || cmd == L_SHR1_B || cmd == L_SHL1_B) need = NEED_B;
    end
    return need;
  endfunction

  // True for the two-cycle multiply commands.
  function automatic logic cmd_is_mul(input logic mode, input logic [CMD_W-1:0] cmd);
    return mode && (cmd == A_MUL_INC || cmd == A_MUL_SHL);
  endfunction

endpackage

// File: rtl/alu_operand_collector.sv
// Operand collector: gathers OPA/OPB (possibly arriving on different cycles),
// times out a missing operand, and sequences the extra multiply cycle.
module alu_operand_collector
  import alu_pkg::*;
#(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         CE,
  input  logic [W-1:0] OPA,
  input  logic [W-1:0] OPB,
  input  logic         Cin,
  input  logic         mode,
  input  logic [1:0]   inp_valid,
  input  logic [N-1:0] CMD,
  output logic         issue,
  output logic         iss_tmo,
  output logic         iss_mul,
  output logic [W-1:0] iss_a,
  output logic [W-1:0] iss_b,
  output logic         iss_cin,
  output logic         iss_mode,
  output logic [N-1:0] iss_cmd,
  output logic         busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  coll_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]     miss_q, miss_d, need;
  logic           mul_q, mul_now, cmd_hi_zero;
  logic           latch_en, cnt_inc;
  logic [W-1:0]   a_q, b_q;
  logic           cin_q, mode_q;
  logic [N-1:0]   cmd_q;

  assign cmd_hi_zero = ((CMD >> CMD_W) == '0);
  assign need        = needs_operands(mode, CMD_W'(CMD));
  assign miss_d      = need & ~inp_valid;
  assign mul_now     = cmd_is_mul(mode, CMD_W'(CMD)) && cmd_hi_zero;

  // Next-state, issue strobe and issued-operand selection.
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    iss_tmo  = 1'b0;
    iss_mul  = 1'b0;
    busy     = 1'b0;
    latch_en = 1'b0;
    cnt_inc  = 1'b0;
    iss_a    = OPA;
    iss_b    = OPB;
    iss_cin  = Cin;
    iss_mode = mode;
    iss_cmd  = CMD;
    case (state_q)
      IDLE: begin
        if (CE && inp_valid != 2'b00) begin
          if (miss_d == 2'b00) begin
            issue   = 1'b1;
            iss_mul = mul_now;
            if (mul_now) state_d = MUL2;
          end else begin
            latch_en = 1'b1;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        busy     = 1'b1;
        // Only the missing operand comes from the pins; the rest was latched.
        iss_a    = miss_q[0] ? OPA : a_q;
        iss_b    = miss_q[1] ? OPB : b_q;
        iss_cin  = cin_q;
        iss_mode = mode_q;
        iss_cmd  = cmd_q;
        if (CE) begin
          if ((inp_valid & miss_q) != 2'b00) begin
            // Arrival wins even on the last allowed cycle.
            issue   = 1'b1;
            iss_mul = mul_q;
            state_d = mul_q ? MUL2 : IDLE;
          end else if (cnt_q == TMO_LAST) begin
            issue   = 1'b1;
            iss_tmo = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      MUL2: begin
        busy = 1'b1;
        if (CE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, timeout counter and pending-operation bookkeeping.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      miss_q  <= 2'b00;
      mul_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        cnt_q  <= '0;
        miss_q <= miss_d;
        mul_q  <= mul_now;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Operand/command capture when an operation has to wait for its partner.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      a_q    <= OPA;
      b_q    <= OPB;
      cin_q  <= Cin;
      mode_q <= mode;
      cmd_q  <= CMD;
    end
  end

endmodule

// File: rtl/alu_pipe_core.sv
// Registered ALU core: operand collector, single-cycle datapath, two-cycle
// multiply path and the output register bank.
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int TIMEOUT = 16,
  parameter int SHIFT_W = $clog2(W)
) (
  input  logic           clk,
  input  logic           RST,
  input  logic           CE,
  input  logic [W-1:0]   OPA,
  input  logic [W-1:0]   OPB,
  input  logic           Cin,
  input  logic           mode,
  input  logic [1:0]     inp_valid,
  input  logic [N-1:0]   CMD,
  output logic [2*W-1:0] RES,
  output logic           OFLOW,
  output logic           COUT,
  output logic           G,
  output logic           L,
  output logic           E,
  output logic           ERR,
  output logic           res_valid,
  output logic           busy
);

  logic           issue, iss_tmo, iss_mul, iss_cin, iss_mode;
  logic [W-1:0]   iss_a, iss_b;
  logic [N-1:0]   iss_cmd;
  logic [CMD_W-1:0] cmd4;
  logic           hi_ok, rot_bad;
  logic [SHIFT_W-1:0] sh;

  logic [2*W-1:0] res_d;
  logic           oflow_d, cout_d, g_d, l_d, e_d, err_d;
  logic [W:0]     sum_d;
  logic [W:0]     mfa_d, mfb_d;

  logic           vld_p0;
  logic [W:0]     mfa_p0, mfb_p0;
  logic [2*W-1:0] prod_p0;

  function automatic logic [2*W-1:0] zx(input logic [W-1:0] v);
    return {{W{1'b0}}, v};
  endfunction

  function automatic logic [2*W-1:0] zx1(input logic [W:0] v);
    return {{(W-1){1'b0}}, v};
  endfunction

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input logic [SHIFT_W-1:0] s);
    return (v << s) | (v >> (W - int'(s)));
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input logic [SHIFT_W-1:0] s);
    return (v >> s) | (v << (W - int'(s)));
  endfunction

  alu_operand_collector #(
    .W(W), .N(N), .TIMEOUT(TIMEOUT)
  ) u_coll (
    .clk(clk), .RST(RST), .CE(CE),
    .OPA(OPA), .OPB(OPB), .Cin(Cin), .mode(mode),
    .inp_valid(inp_valid), .CMD(CMD),
    .issue(issue), .iss_tmo(iss_tmo), .iss_mul(iss_mul),
    .iss_a(iss_a), .iss_b(iss_b), .iss_cin(iss_cin),
    .iss_mode(iss_mode), .iss_cmd(iss_cmd), .busy(busy)
  );

  assign cmd4    = CMD_W'(iss_cmd);
  assign hi_ok   = ((iss_cmd >> CMD_W) == '0);
  assign sh      = iss_b[SHIFT_W-1:0];
  assign rot_bad = ((iss_b >> SHIFT_W) != '0);

  // Single-cycle result and flags for the operation being issued.
  always_comb begin
    res_d   = '0;
    oflow_d = 1'b0;
    cout_d  = 1'b0;
    g_d     = 1'b0;
    l_d     = 1'b0;
    e_d     = 1'b0;
    err_d   = 1'b0;
    sum_d   = '0;
    if (iss_tmo || !hi_ok) begin
      err_d = 1'b1;
    end else if (iss_mode) begin
      case (cmd4)
        A_ADD: begin
          sum_d  = {1'b0, iss_a} + {1'b0, iss_b};
          res_d  = zx1(sum_d);
          cout_d = sum_d[W];
        end
        A_ADD_CIN: begin
          sum_d  = {1'b0, iss_a} + {1'b0, iss_b} + (W+1)'(iss_cin);
          res_d  = zx1(sum_d);
          cout_d = sum_d[W];
        end
        A_SUB: begin
          res_d   = zx(iss_a - iss_b);
          oflow_d = (iss_a < iss_b);
        end
        A_SUB_CIN: begin
          res_d   = zx(iss_a - iss_b - W'(iss_cin));
          oflow_d = ({1'b0, iss_a} < ({1'b0, iss_b} + (W+1)'(iss_cin)));
        end
        A_INC_A: begin res_d = zx(iss_a + W'(1)); cout_d  = &iss_a;  end
        A_DEC_A: begin res_d = zx(iss_a - W'(1)); oflow_d = ~|iss_a; end
        A_INC_B: begin res_d = zx(iss_b + W'(1)); cout_d  = &iss_b;  end
        A_DEC_B: begin res_d = zx(iss_b - W'(1)); oflow_d = ~|iss_b; end
        A_CMP: begin
          g_d = (iss_a > iss_b);
          l_d = (iss_a < iss_b);
          e_d = (iss_a == iss_b);
        end
        A_MUL_INC, A_MUL_SHL: res_d = '0;
        default: err_d = 1'b1;
      endcase
    end else begin
      case (cmd4)
        L_AND:    res_d = zx(iss_a & iss_b);
        L_NAND:   res_d = zx(~(iss_a & iss_b));
        L_OR:     res_d = zx(iss_a | iss_b);
        L_NOR:    res_d = zx(~(iss_a | iss_b));
        L_XOR:    res_d = zx(iss_a ^ iss_b);
        L_XNOR:   res_d = zx(~(iss_a ^ iss_b));
        L_NOT_A:  res_d = zx(~iss_a);
        L_NOT_B:  res_d = zx(~iss_b);
        L_SHR1_A: res_d = zx(iss_a >> 1);
        L_SHL1_A: res_d = zx(iss_a << 1);
        L_SHR1_B: res_d = zx(iss_b >> 1);
        L_SHL1_B: res_d = zx(iss_b << 1);
        L_ROL_A_B: begin
          if (rot_bad) err_d = 1'b1;
          else         res_d = zx(rotl(iss_a, sh));
        end
        L_ROR_A_B: begin
          if (rot_bad) err_d = 1'b1;
          else         res_d = zx(rotr(iss_a, sh));
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // Multiply factors: (A+1)*(B+1) or (2A)*B, each factor W+1 bits wide.
  always_comb begin
    mfa_d = {iss_a, 1'b0};
    mfb_d = {1'b0, iss_b};
    if (cmd4 == A_MUL_INC) begin
      mfa_d = {1'b0, iss_a} + (W+1)'(1);
      mfb_d = {1'b0, iss_b} + (W+1)'(1);
    end
  end

  // ---- stage p0: multiply factor register (first multiply cycle) ----
  // Multiply-in-flight flag; flushed by reset so a dropped multiply never reports.
  always_ff @(posedge clk) begin
    if (RST)     vld_p0 <= 1'b0;
    else if (CE) vld_p0 <= issue & iss_mul;
  end

  // Multiply factors captured on a multiply issue.
  always_ff @(posedge clk) begin
    if (CE && issue && iss_mul) begin
      mfa_p0 <= mfa_d;
      mfb_p0 <= mfb_d;
    end
  end

  assign prod_p0 = (2*W)'(mfa_p0) * (2*W)'(mfb_p0);

  // ---- stage p1: output register bank ----
  // Result/flag register; the strobe lasts one cycle and never fires on a CE=0 edge.
  always_ff @(posedge clk) begin
    if (RST) begin
      RES       <= '0;
      OFLOW     <= 1'b0;
      COUT      <= 1'b0;
      G         <= 1'b0;
      L         <= 1'b0;
      E         <= 1'b0;
      ERR       <= 1'b0;
      res_valid <= 1'b0;
    end else if (!CE) begin
      res_valid <= 1'b0;
    end else if (vld_p0) begin
      RES       <= prod_p0;
      OFLOW     <= 1'b0;
      COUT      <= 1'b0;
      G         <= 1'b0;
      L         <= 1'b0;
      E         <= 1'b0;
      ERR       <= 1'b0;
      res_valid <= 1'b1;
    end else if (issue && !iss_mul) begin
      RES       <= res_d;
      OFLOW     <= oflow_d;
      COUT      <= cout_d;
      G         <= g_d;
      L         <= l_d;
      E         <= e_d;
      ERR       <= err_d;
      res_valid <= 1'b1;
    end else begin
      res_valid <= 1'b0;
    end
  end

endmodule
